reserved_entry_gate: RTL and testbench

RESERVED_ENTRY_GATE -- requirements
Module: reserved_entry_gate

---
 rtl/reserved_entry_gate.sv | 166 ++++++++++++++++
 tb/tb_reserved_entry_gate.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reserved_entry_gate.sv
// -----------------------------------------------------------------------------
// reserved_entry_gate
//
// Purpose: entry barrier controller for a reserved car park. Each flat
// 0..N owns one reserved slot. The block accepts a flat number from the
// reader and checks it against the occupancy map. A flat whose slot is
// free is admitted: its slot is marked occupied and the barrier opens for
// GATE_CYC cycles. An occupied slot or an out-of-range flat is rejected.
// The exit stage reports departing vehicles, which free their slot again.
//
// Ports:
//   clk, rst              single clock; synchronous active-high reset
//   req_valid/req_flat    entry request; req_ready is high only in IDLE
//   exit_valid/exit_flat  one-cycle exit notification
//   resp_valid/resp_code  one-cycle decision pulse
//                         (00 admit, 01 occupied, 10 flat > N)
//   gate_open             barrier drive, high for GATE_CYC cycles per admit
//   occupancy             bit k set while flat k's slot is taken
//   free_cnt              number of free slots (N+1 - popcount(occupancy))
//   exit_err              one-cycle pulse for an exit of an empty slot or flat > N
// -----------------------------------------------------------------------------
module reserved_entry_gate #(
    parameter int N        = 15,
    parameter int FW       = 4,
    parameter int GATE_CYC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [FW-1:0] req_flat,
    output logic          req_ready,
    input  logic          exit_valid,
    input  logic [FW-1:0] exit_flat,
    output logic          resp_valid,
    output logic [1:0]    resp_code,
    output logic          gate_open,
    output logic [N:0]    occupancy,
    output logic [FW:0]   free_cnt,
    output logic          exit_err
);

    localparam int CW   = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
    localparam int CNTW = FW + 1;

    typedef enum logic [1:0] {IDLE, CHECK, OPEN, REJECT} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   flat_q, flat_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N:0]      occupancy_q, occupancy_d;
    logic [CNTW-1:0] free_cnt_q, free_cnt_d;
    logic            resp_valid_q, resp_valid_d;
    logic [1:0]      resp_code_q, resp_code_d;
    logic            exit_err_q, exit_err_d;

    logic            set_en;
    logic [N:0]      flat_dec;
    logic [N:0]      exit_dec;
    logic [N:0]      set_vec;
    logic [N:0]      clr_vec;
    logic            flat_in_range;
    logic            flat_hit;
    logic            exit_ok;

    // One-hot decodes of the registered request flat and the exit flat.
    // A flat above N matches no bit, so "no bit set" means out of range.
    for (genvar gi = 0; gi <= N; gi++) begin : g_dec
        assign flat_dec[gi] = (flat_q == FW'(gi));
        assign exit_dec[gi] = (exit_flat == FW'(gi));
    end

    assign flat_in_range = |flat_dec;
    assign flat_hit      = |(flat_dec & occupancy_q);

    // Request FSM
    always_comb begin
        state_d     = state_q;
        flat_d      = flat_q;
        cnt_d       = cnt_q;
        resp_valid_d = 1'b0;
        resp_code_d = resp_code_q;
        set_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    flat_d  = req_flat;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Decision uses occupancy as it stood at the start of this
                // cycle, so a simultaneous exit of the same flat still rejects.
                resp_valid_d = 1'b1;
                if (!flat_in_range) begin
                    resp_code_d = 2'b10;
                    state_d     = REJECT;
                end else if (flat_hit) begin
                    resp_code_d = 2'b01;
                    state_d     = REJECT;
                end else begin
                    resp_code_d = 2'b00;
                    set_en      = 1'b1;
                    cnt_d       = CW'(GATE_CYC - 1);
                    state_d     = OPEN;
                end
            end
            OPEN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            REJECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Occupancy and free counter. Only occupied bits can be cleared and only
    // free bits can be set, so set and clear never hit the same bit. An exit
    // naming the slot being admitted on this same edge is treated as a clear
    // that loses to the set: it is not an error and leaves the bit set.
    always_comb begin
        set_vec     = set_en ? flat_dec : '0;
        clr_vec     = exit_valid ? (exit_dec & occupancy_q) : '0;
        exit_ok     = |(exit_dec & (occupancy_q | set_vec));
        exit_err_d  = exit_valid & ~exit_ok;
        occupancy_d = (occupancy_q & ~clr_vec) | set_vec;
        free_cnt_d  = free_cnt_q + CNTW'(|clr_vec) - CNTW'(|set_vec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            flat_q       <= '0;
            cnt_q        <= '0;
            occupancy_q  <= '0;
            free_cnt_q   <= CNTW'(N + 1);
            resp_valid_q <= 1'b0;
            resp_code_q  <= 2'b00;
            exit_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flat_q       <= flat_d;
            cnt_q        <= cnt_d;
            occupancy_q  <= occupancy_d;
            free_cnt_q   <= free_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
            exit_err_q   <= exit_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign gate_open  = (state_q == OPEN);
    assign resp_valid = resp_valid_q;
    assign resp_code  = resp_code_q;
    assign occupancy  = occupancy_q;
    assign free_cnt   = free_cnt_q;
    assign exit_err   = exit_err_q;

endmodule

// File: tb/tb_reserved_entry_gate.sv
// -----------------------------------------------------------------------------
// tb_reserved_entry_gate
//
// Directed bench for reserved_entry_gate with N=15, FW=5, GATE_CYC=8.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reserved_entry_gate;

    localparam int N        = 15;
    localparam int FW       = 5;
    localparam int GATE_CYC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [FW-1:0] req_flat;
    logic          req_ready;
    logic          exit_valid;
    logic [FW-1:0] exit_flat;
    logic          resp_valid;
    logic [1:0]    resp_code;
    logic          gate_open;
    logic [N:0]    occupancy;
    logic [FW:0]   free_cnt;
    logic          exit_err;

    int checks   = 0;
    int failures = 0;

    reserved_entry_gate #(.N(N), .FW(FW), .GATE_CYC(GATE_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_flat   (req_flat),
        .req_ready  (req_ready),
        .exit_valid (exit_valid),
        .exit_flat  (exit_flat),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .gate_open  (gate_open),
        .occupancy  (occupancy),
        .free_cnt   (free_cnt),
        .exit_err   (exit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  flat;
        logic [1:0]  code;
        logic [15:0] occ;
        int          free;
    } req_vec_t;

    typedef struct {
        logic [4:0]  flat;
        logic        err;
        logic [15:0] occ;
        int          free;
    } exit_vec_t;

    req_vec_t  rtab[6];
    exit_vec_t etab[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input req_vec_t v, input int idx);
        int g = 0;
        int rv = 0;
        wait_ready();
        req_valid = 1'b1;
        req_flat  = v.flat;
        @(negedge clk);
        req_valid = 1'b0;
        chk("resp_early", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_code", 32'(resp_code), 32'(v.code));
        chk("occupancy", 32'(occupancy), 32'(v.occ));
        chk("free_cnt", 32'(free_cnt), 32'(v.free));
        for (int i = 0; i < 12; i++) begin
            g  += int'(gate_open);
            rv += int'(resp_valid);
            @(negedge clk);
        end
        chk("gate_cycles", 32'(g), (v.code == 2'b00) ? 32'd8 : 32'd0);
        chk("resp_pulses", 32'(rv), 32'd1);
        $display("req  #%0d flat=%0d code=%0d occ=%h free=%0d gate_cycles=%0d",
                 idx, v.flat, resp_code, occupancy, free_cnt, g);
    endtask

    task automatic do_exit(input exit_vec_t v, input int idx);
        exit_valid = 1'b1;
        exit_flat  = v.flat;
        @(negedge clk);
        exit_valid = 1'b0;
        chk("exit_err", 32'(exit_err), 32'(v.err));
        chk("exit_occ", 32'(occupancy), 32'(v.occ));
        chk("exit_free", 32'(free_cnt), 32'(v.free));
        @(negedge clk);
        chk("exit_err_pulse", 32'(exit_err), 32'd0);
        $display("exit #%0d flat=%0d occ=%h free=%0d", idx, v.flat, occupancy, free_cnt);
    endtask

    initial begin
        rtab[0] = '{flat: 5'd5,  code: 2'b00, occ: 16'h0020, free: 15};
        rtab[1] = '{flat: 5'd5,  code: 2'b01, occ: 16'h0020, free: 15};
        rtab[2] = '{flat: 5'd20, code: 2'b10, occ: 16'h0020, free: 15};
        rtab[3] = '{flat: 5'd0,  code: 2'b00, occ: 16'h0021, free: 14};
        rtab[4] = '{flat: 5'd15, code: 2'b00, occ: 16'h8021, free: 13};
        rtab[5] = '{flat: 5'd16, code: 2'b10, occ: 16'h8021, free: 13};

        etab[0] = '{flat: 5'd3,  err: 1'b1, occ: 16'h8021, free: 13};
        etab[1] = '{flat: 5'd5,  err: 1'b0, occ: 16'h8001, free: 14};
        etab[2] = '{flat: 5'd20, err: 1'b1, occ: 16'h8001, free: 14};
        etab[3] = '{flat: 5'd15, err: 1'b0, occ: 16'h0001, free: 15};
        etab[4] = '{flat: 5'd0,  err: 1'b0, occ: 16'h0000, free: 16};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_flat   = '0;
        exit_valid = 1'b0;
        exit_flat  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_code", 32'(resp_code), 32'd0);
        chk("rst_gate", 32'(gate_open), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_free", 32'(free_cnt), 32'd16);
        chk("rst_exit_err", 32'(exit_err), 32'd0);
        $display("reset occ=%h free=%0d ready=%0d", occupancy, free_cnt, req_ready);

        for (int i = 0; i < 6; i++) do_req(rtab[i], i);
        for (int i = 0; i < 5; i++) do_exit(etab[i], i);

        // Exit of flat 7 lands on the same edge that admits flat 7: set wins.
        wait_ready();
        req_valid = 1'b1;
        req_flat  = 5'd7;
        @(negedge clk);
        req_valid  = 1'b0;
        exit_valid = 1'b1;
        exit_flat  = 5'd7;
        @(negedge clk);
        exit_valid = 1'b0;
        chk("same_edge_resp", 32'(resp_valid), 32'd1);
        chk("same_edge_code", 32'(resp_code), 32'd0);
        chk("same_edge_occ", 32'(occupancy), 32'h0080);
        chk("same_edge_free", 32'(free_cnt), 32'd15);
        chk("same_edge_err", 32'(exit_err), 32'd0);
        chk("same_edge_gate", 32'(gate_open), 32'd1);
        $display("same-edge flat=7 code=%0d occ=%h free=%0d", resp_code, occupancy, free_cnt);

        // Flat 7 occupied; its exit arrives during the CHECK of a new request for 7.
        wait_ready();
        req_valid = 1'b1;
        req_flat  = 5'd7;
        @(negedge clk);
        req_valid  = 1'b0;
        exit_valid = 1'b1;
        exit_flat  = 5'd7;
        @(negedge clk);
        exit_valid = 1'b0;
        chk("chk_exit_resp", 32'(resp_valid), 32'd1);
        chk("chk_exit_code", 32'(resp_code), 32'd1);
        chk("chk_exit_occ", 32'(occupancy), 32'd0);
        chk("chk_exit_free", 32'(free_cnt), 32'd16);
        chk("chk_exit_gate", 32'(gate_open), 32'd0);
        $display("exit-in-check flat=7 code=%0d occ=%h free=%0d", resp_code, occupancy, free_cnt);

        // Reset three cycles into OPEN aborts the admission.
        wait_ready();
        req_valid = 1'b1;
        req_flat  = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_gate_c2", 32'(gate_open), 32'd1);
        chk("abort_occ_c2", 32'(occupancy), 32'h0200);
        @(negedge clk);
        @(negedge clk);
        chk("abort_gate_c4", 32'(gate_open), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_gate", 32'(gate_open), 32'd0);
        chk("abort_occ", 32'(occupancy), 32'd0);
        chk("abort_free", 32'(free_cnt), 32'd16);
        chk("abort_ready", 32'(req_ready), 32'd1);
        begin
            int act = 0;
            for (int i = 0; i < 10; i++) begin
                act += int'(resp_valid) + int'(gate_open);
                @(negedge clk);
            end
            chk("abort_quiet", 32'(act), 32'd0);
        end
        $display("abort occ=%h free=%0d gate=%0d", occupancy, free_cnt, gate_open);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
